// File: rtl/sd_block_hexdump.sv
// Purpose: reads bytes from the SD buffer SRAM and prints them as uppercase hex text lines ending in CR LF over a byte UART.
// Latency: the first transmit comes 3 cycles after start (1 cycle with HEXDUMP_ADDR_PREFIX_EN); each new byte costs 2 FETCH/LATCH cycles.
// Backpressure: each character holds transmit until is_transmitting rises, then waits for it to fall; there is no timeout.
// Option: define HEXDUMP_ADDR_PREFIX_EN to begin every line with "XXX: " (the starting byte offset in hex).
module sd_block_hexdump #(
  parameter int BYTES_PER_LINE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] len,
  output logic [8:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       transmit,
  output logic [7:0] tx_byte,
  input  logic       is_transmitting,
  output logic       busy,
  output logic       done
);

  localparam logic [9:0] LP_COL_LAST = 10'(BYTES_PER_LINE - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LATCH, S_HI, S_LO, S_SEP, S_CR, S_LF,
`ifdef HEXDUMP_ADDR_PREFIX_EN
    S_ADDR,
`endif
    S_FIN
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_ph;      // 0: waiting for the UART to pick up the character, 1: waiting for it to finish
  logic [9:0] r_idx;
  logic [9:0] r_col;
  logic [9:0] r_len;
  logic [7:0] r_byte;
  logic [7:0] r_hold;    // last character sent; tx_byte keeps this value between characters
`ifdef HEXDUMP_ADDR_PREFIX_EN
  logic [2:0] r_acnt;    // which prefix character is being sent, 0..4
`endif

  logic       w_send;
  logic       w_adv;
  logic       w_last;
  logic       w_line_end;
  logic [7:0] w_char;
  logic [9:0] w_len_eff;

  function automatic logic [7:0] f_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign w_len_eff  = ((len == 10'd0) || (len > 10'd512)) ? 10'd512 : len;
  assign w_last     = (r_idx == (r_len - 10'd1));
  assign w_line_end = (r_col == LP_COL_LAST);
  assign w_adv      = w_send & r_ph & ~is_transmitting;

  assign rd_addr  = r_idx[8:0];
  assign transmit = w_send & ~r_ph;
  assign tx_byte  = w_char;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_FIN);

  // Work out which states send a character, and which character each one sends
  always_comb begin
    w_send = 1'b0;
    w_char = r_hold;
    case (r_state)
      S_HI:  begin w_send = 1'b1; w_char = f_hex(r_byte[7:4]); end
      S_LO:  begin w_send = 1'b1; w_char = f_hex(r_byte[3:0]); end
      S_SEP: begin w_send = 1'b1; w_char = 8'h20; end
      S_CR:  begin w_send = 1'b1; w_char = 8'h0D; end
      S_LF:  begin w_send = 1'b1; w_char = 8'h0A; end
`ifdef HEXDUMP_ADDR_PREFIX_EN
      S_ADDR: begin
        w_send = 1'b1;
        case (r_acnt)
          3'd0:    w_char = f_hex({3'b000, r_idx[8]});
          3'd1:    w_char = f_hex(r_idx[7:4]);
          3'd2:    w_char = f_hex(r_idx[3:0]);
          3'd3:    w_char = 8'h3A;
          default: w_char = 8'h20;
        endcase
      end
`endif
      default: begin w_send = 1'b0; w_char = r_hold; end
    endcase
  end

  // Next-state logic; a sending state moves on only once its character has finished
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef HEXDUMP_ADDR_PREFIX_EN
          w_next = S_ADDR;
`else
          w_next = S_FETCH;
`endif
        end
      end
      S_FETCH: w_next = S_LATCH;
      S_LATCH: w_next = S_HI;
`ifdef HEXDUMP_ADDR_PREFIX_EN
      S_ADDR:  if (w_adv && (r_acnt == 3'd4)) w_next = S_FETCH;
`endif
      S_HI:    if (w_adv) w_next = S_LO;
      S_LO:    if (w_adv) w_next = (w_last || w_line_end) ? S_CR : S_SEP;
      S_SEP:   if (w_adv) w_next = S_FETCH;
      S_CR:    if (w_adv) w_next = S_LF;
      S_LF: begin
        if (w_adv) begin
          if (w_last) begin
            w_next = S_FIN;
          end else begin
`ifdef HEXDUMP_ADDR_PREFIX_EN
            w_next = S_ADDR;
`else
            w_next = S_FETCH;
`endif
          end
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Datapath: length and index tracking, byte capture, and the per-character handshake phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ph   <= 1'b0;
      r_idx  <= 10'd0;
      r_col  <= 10'd0;
      r_len  <= 10'd0;
      r_byte <= 8'h00;
      r_hold <= 8'h00;
`ifdef HEXDUMP_ADDR_PREFIX_EN
      r_acnt <= 3'd0;
`endif
    end else begin
      if (!w_send)                        r_ph <= 1'b0;
      else if (!r_ph && is_transmitting)  r_ph <= 1'b1;
      else if (r_ph && !is_transmitting)  r_ph <= 1'b0;

      if (w_send) r_hold <= w_char;

      if ((r_state == S_IDLE) && start) begin
        r_len <= w_len_eff;
        r_idx <= 10'd0;
        r_col <= 10'd0;
`ifdef HEXDUMP_ADDR_PREFIX_EN
        r_acnt <= 3'd0;
`endif
      end

      if (r_state == S_LATCH) r_byte <= rd_data;

      if ((r_state == S_SEP) && w_adv) begin
        r_idx <= r_idx + 10'd1;
        r_col <= r_col + 10'd1;
      end

      if ((r_state == S_LF) && w_adv && !w_last) begin
        r_idx <= r_idx + 10'd1;
        r_col <= 10'd0;
`ifdef HEXDUMP_ADDR_PREFIX_EN
        r_acnt <= 3'd0;
`endif
      end

`ifdef HEXDUMP_ADDR_PREFIX_EN
      if ((r_state == S_ADDR) && w_adv) r_acnt <= r_acnt + 3'd1;
`endif
    end
  end

endmodule

// File: tb/tb_sd_block_hexdump.sv
`timescale 1ns/1ps
module tb_sd_block_hexdump;
  localparam int BPL = 16;
`ifdef HEXDUMP_ADDR_PREFIX_EN
  localparam int PFX = 5;
  localparam int LAT = 1;
`else
  localparam int PFX = 0;
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] len = 10'd0;
  logic [8:0] rd_addr;
  logic [7:0] rd_data;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       is_transmitting = 1'b0;
  logic       busy;
  logic       done;

  sd_block_hexdump #(.BYTES_PER_LINE(BPL)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .transmit(transmit), .tx_byte(tx_byte), .is_transmitting(is_transmitting),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // SRAM with a synchronous read port
  logic [7:0] mem [512];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];
  int acc_cnt = 0;
  int done_cnt = 0;
  int max_addr = 0;
  int accept_dly = 0;
  int busy_cyc = 1;
  bit rnd_dly = 1'b0;
  int u_st = 0;
  int u_cnt = 0;
  logic [7:0] u_cap = 8'h00;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] hexc(input int v);
    return 8'((v < 10) ? (48 + v) : (55 + v));
  endfunction

  // Reference model: the full text of a dump of n bytes
  function automatic void build_exp(input int n);
    exp_q.delete();
    for (int base = 0; base < n; base += BPL) begin
      if (PFX != 0) begin
        exp_q.push_back(hexc(base / 256));
        exp_q.push_back(hexc((base / 16) % 16));
        exp_q.push_back(hexc(base % 16));
        exp_q.push_back(8'h3A);
        exp_q.push_back(8'h20);
      end
      for (int k = 0; k < BPL && base + k < n; k++) begin
        if (k > 0) exp_q.push_back(8'h20);
        exp_q.push_back(hexc(int'(mem[base + k]) / 16));
        exp_q.push_back(hexc(int'(mem[base + k]) % 16));
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  // UART model and character monitor: accepts each character after a delay and compares it with the model
  initial begin : uart
    forever begin
      @(negedge clk);
      if (reset) begin
        u_st = 0;
        is_transmitting = 1'b0;
      end else begin
        case (u_st)
          0: if (transmit) begin
               u_cap = tx_byte;
               u_cnt = rnd_dly ? int'($urandom_range(0, 3)) : accept_dly;
               u_st = 1;
             end
          1: begin
               chk("tx_hold", {23'd0, transmit, tx_byte}, {23'd0, 1'b1, u_cap});
               if (u_cnt > 0) u_cnt--;
             end
          default: begin
               if (u_cnt > 0) u_cnt--;
               else begin
                 is_transmitting = 1'b0;
                 u_st = 0;
               end
             end
        endcase
        if (u_st == 1 && u_cnt == 0) begin
          is_transmitting = 1'b1;
          acc_cnt++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_char: got 0x%0h, want none", tx_byte);
          end else begin
            chk("char", tx_byte, exp_q.pop_front());
          end
          u_cnt = rnd_dly ? int'($urandom_range(0, 3)) : busy_cyc;
          u_st = 2;
        end
      end
    end
  end

  // Counts done pulses and tracks the highest read address used during a dump
  initial begin : mon
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy && int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
    end
  end

  task automatic run_dump(input int l, input int want_chars, input int restart_at, input bit rel_reset);
    int eff, d0, a0, nexp, budget, k;
    eff = (l == 0 || l > 512) ? 512 : l;
    build_exp(eff);
    nexp = exp_q.size();
    d0 = done_cnt;
    a0 = acc_cnt;
    max_addr = 0;
    @(negedge clk);
    if (rel_reset) reset = 1'b0;
    start = 1'b1;
    len = l[9:0];
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", busy, 1);
    k = 1;
    while (!transmit && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("first_tx_latency", k, LAT);
    budget = (nexp + eff * 2 + 20) * (rnd_dly ? 8 : accept_dly + busy_cyc + 4);
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      k++;
      if (k == restart_at) begin
        start = 1'b1;
        len = 10'd5;
      end else if (k == restart_at + 1) begin
        start = 1'b0;
      end
    end
    chk("done_seen", done_cnt - d0, 1);
    repeat (3) @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_pulses", done_cnt - d0, 1);
    chk("chars_left", exp_q.size(), 0);
    chk("char_count", acc_cnt - a0, (want_chars < 0) ? nexp : want_chars);
    chk("rd_addr_in_range", int'(max_addr <= eff - 1), 1);
  endtask

  initial begin : global_guard
    #900000;
    $display("FAIL global_timeout: got no end, want summary");
    $fatal(1, "timeout");
  end

  initial begin : main
    int a0, k;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_transmit", transmit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_tx_byte", tx_byte, 0);
    reset = 1'b0;

    // Single byte 0xEB, slow UART
    mem[0] = 8'hEB;
    busy_cyc = 10;
    run_dump(1, 4 + PFX, 0, 1'b0);

    // Incrementing bytes, 17 bytes -> a full line plus one byte
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    busy_cyc = 2;
    run_dump(17, 53 + 2 * PFX, 0, 1'b0);

    // len=0 means the whole buffer, all 0xFF
    for (int i = 0; i < 512; i++) mem[i] = 8'hFF;
    busy_cyc = 1;
    run_dump(0, 1568 + 32 * PFX, 0, 1'b0);

    // Oversized length clamps to 512, random data
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    run_dump(int'($urandom_range(513, 1023)), -1, 0, 1'b0);

    // A start pulse mid-dump is ignored
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    busy_cyc = 2;
    run_dump(20, -1, 60, 1'b0);

    // UART slow to pick up: transmit must hold with a stable byte
    accept_dly = 20;
    busy_cyc = 3;
    run_dump(2, -1, 0, 1'b0);
    accept_dly = 0;

    // Random lengths and random UART timing
    rnd_dly = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
      run_dump(int'($urandom_range(1, 80)), -1, 0, 1'b0);
    end
    rnd_dly = 1'b0;

    // Async reset while the third character is offered
    accept_dly = 3;
    busy_cyc = 2;
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    build_exp(20);
    @(negedge clk);
    start = 1'b1;
    len = 10'd20;
    @(negedge clk);
    start = 1'b0;
    a0 = acc_cnt;
    k = 0;
    while (!((acc_cnt - a0) == 2 && transmit) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("reach_third_char", acc_cnt - a0, 2);
    #1 reset = 1'b1;
    #1;
    chk("arst_transmit", transmit, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_rd_addr", rd_addr, 0);
    chk("arst_tx_byte", tx_byte, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    accept_dly = 0;
    mem[0] = 8'h3C;
    run_dump(1, 4 + PFX, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sd_block_hexdump.md
# sd_block_hexdump

Downstream consumer of the SD block reader's 512-byte SRAM buffer. On a start pulse it reads a programmable number of bytes through the buffer's synchronous read port and formats them as uppercase ASCII hex text. The text goes out through the byte-wide UART transmitter's `transmit`/`is_transmitting` handshake, 16 bytes per line, each line terminated by CR LF.

## Interface
- `BYTES_PER_LINE`, default 16: bytes printed per text line; must be 1..512.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to dump; sampled only in IDLE.
- `len`  in  10  bytes to dump, captured at `start`; legal 0..512, 0 means 512, values >512 clamp to 512.
- `rd_addr`  out  9  SRAM read address; reset 0.
- `rd_data`  in  8  SRAM read data, valid the cycle after `rd_addr` is presented.
- `transmit`  out  1  UART send request; reset 0.
- `tx_byte`  out  8  character to send; reset 0x00.
- `is_transmitting`  in  1  UART busy flag.
- `busy`  out  1  high from the cycle after accepted `start` until `done`; reset 0.
- `done`  out  1  one-cycle pulse after the last LF is fully transmitted; reset 0.

## Operation
- FSM states: IDLE, FETCH, LATCH, [ADDR: `ADDR_PREFIX_EN` only], HI, LO, SEP, CR, LF, FIN.
- IDLE: on `start`, latch `len` (0→512, >512→512), clear byte index `idx` (10 bit) and line column `col`, go to FETCH. If `ADDR_PREFIX_EN` is defined, go to ADDR instead.
- FETCH: drive `rd_addr = idx[8:0]`, then go to LATCH.
- LATCH: capture `rd_data` into `byte_r`, then go to HI.
- HI / LO: send the hex character of `byte_r[7:4]` / `byte_r[3:0]`.
  - Nibble 0–9 maps to 0x30–0x39.
  - Nibble A–F maps to 0x41–0x46 (uppercase).
- After LO:
  - If `idx == len-1` or `col == BYTES_PER_LINE-1`, go to CR.
  - Otherwise go to SEP, which sends a space (0x20).
- SEP: after the send, `idx++`, `col++`, then go to FETCH.
- CR: send 0x0D. LF: send 0x0A.
- After LF:
  - If the byte just printed was the last one (`idx == len-1`), go to FIN.
  - Otherwise `idx++`, `col=0`, then go to FETCH (or to ADDR if `ADDR_PREFIX_EN` is defined).
- FIN: pulse `done`, clear `busy`, return to IDLE.
- Character send sub-handshake, used by every sending state:
  - WAIT: `transmit=1`, `tx_byte` stable; leave when `is_transmitting==1`.
  - SEND: `transmit=0`; leave when `is_transmitting==0`.
  - The state only advances after SEND exits.
- `start` while busy is ignored and has no side effects.
- No timeout: a stuck `is_transmitting` holds the FSM indefinitely; only `reset` recovers.

## Timing
- Start to first `transmit`: 3 cycles. Cycle 0 is IDLE seeing `start`; then FETCH, LATCH; `transmit` is high in cycle 3. With `ADDR_PREFIX_EN`, the first `transmit` is the prefix's first character, at cycle 1.
- Byte to byte: 2 cycles of FETCH/LATCH between the end of the SEP/LF handshake and the next HI `transmit`.
- `tx_byte` must not change while `transmit` is high.
- `tx_byte` holds its last value when idle.
- `busy` rises the cycle after `start` is accepted.
- `done` and `busy` fall in the same cycle.
- Async reset mid-operation:
  - Outputs go to their reset values immediately.
  - The FSM goes to IDLE and the partial line is abandoned.
  - A `start` in the first cycle after reset deasserts is honoured.
- `idx` never exceeds 511.
- `rd_addr` is never driven beyond `len-1`.

## Configuration
- `HEXDUMP_ADDR_PREFIX_EN` defined: every line is prefixed by its starting byte offset.
  - Format: 3 uppercase hex digits of `idx[8:0]`, then ':' (0x3A) and a space (0x20); 5 characters total.
  - Sent via the ADDR state using the same handshake.
- Not defined: the ADDR state and offset logic are absent; lines start directly with the first byte's hex.

## Test plan
- `len=1`, `rd_data` for address 0 = 0xEB, UART model busy 10 cycles per char → characters 0x45,0x42,0x0D,0x0A; one `done` pulse; `busy` low afterwards.
- `len=17`, SRAM[i]=i → line 1 is "00 01 … 0F" then CR LF (49 chars); line 2 is "10" then CR LF (4 chars); 53 chars total; `rd_addr` never exceeds 16.
- `len=0`, SRAM all 0xFF → 32 lines × 49 chars = 1568 chars, all hex digits 'F'. With `HEXDUMP_ADDR_PREFIX_EN`: 1728 chars; line 2 starts "010: ", last line starts "1F0: ".
- `start` pulsed again mid-dump with `len=5` → ignored; original length completes; exactly one `done`.
- `reset` asserted while `transmit`=1 in the 3rd character → `transmit`, `busy`, `done`, `rd_addr`, `tx_byte` go to 0 without a clock edge; a new `start` with `len=1` produces a correct 4-char dump.
- UART model holding `is_transmitting` low for 20 cycles → `transmit` held high with `tx_byte` stable; no state advance until busy is seen and then released.
